psa_seq_unit: RTL and testbench

Sequential counterpart to the combinational parallel sub-word adder. It performs nibble-lane signed add or subtract over a 16-bit operand pair, one 4-bit lane per cycle, using a start/busy/done handshake. Each lane result is saturated or wrapped, and a per-lane overflow flag is recorded. The block sits beside the ALU as a multi-cycle PADDSB/PSUBSB engine for area-constrained builds.

---
 rtl/psa_seq_unit.sv | 122 ++++++++++++
 tb/tb_psa_seq_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/psa_seq_unit.sv
// Sequential nibble-lane signed add/subtract engine (PADDSB/PSUBSB).
// One 4-bit lane is processed per clock through a single shared lane adder,
// with a start/busy/done handshake and per-lane overflow flags.

// Shared lane adder: a + b, or a + ~b + 1 when subtracting, with optional clamp.
module psa_lane_add #(
  parameter int SATURATE = 1
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] res,
  output logic       ovf
);
  logic [3:0] b_eff;
  logic [3:0] raw;

  assign b_eff = sub ? ~b : b;
  assign raw   = a + b_eff + {3'b000, sub};
  // Overflow: effective operand signs agree but the result sign differs.
  assign ovf   = (a[3] == b_eff[3]) && (raw[3] != a[3]);

  // Clamp toward the sign of the operands when saturating, else keep the wrap.
  always_comb begin
    res = raw;
    if (ovf && (SATURATE != 0)) res = a[3] ? 4'h8 : 4'h7;
  end
endmodule

module psa_seq_unit #(
  parameter int SATURATE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic [3:0]  Ovfl,
  output logic        Error,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
  } psa_req_t;

  state_t     state;
  psa_req_t   req_q;
  logic [1:0] lane_cnt;
  logic [3:0] lane_a;
  logic [3:0] lane_b;
  logic [3:0] lane_res;
  logic       lane_ovf;

  // Select the current lane from the latched operands.
  assign lane_a = req_q.a[{lane_cnt, 2'b00} +: 4];
  assign lane_b = req_q.b[{lane_cnt, 2'b00} +: 4];

  psa_lane_add #(.SATURATE(SATURATE)) u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .sub (req_q.sub),
    .res (lane_res),
    .ovf (lane_ovf)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      req_q    <= '0;
      lane_cnt <= 2'd0;
      Sum      <= '0;
      Ovfl     <= '0;
      Error    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            req_q    <= '{a: A, b: B, sub: sub};
            Sum      <= '0;
            Ovfl     <= '0;
            Error    <= 1'b0;
            lane_cnt <= 2'd0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          Sum[{lane_cnt, 2'b00} +: 4] <= lane_res;
          Ovfl[lane_cnt]              <= lane_ovf;
          lane_cnt                    <= lane_cnt + 2'd1;
          if (lane_cnt == 2'd3) begin
            // Lane 3's flag is not in Ovfl yet, so fold it in directly.
            Error <= lane_ovf | (|Ovfl[2:0]);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psa_seq_unit.sv
// Bench for psa_seq_unit: saturating and wrapping instances share stimulus;
// a scoreboard queue holds expected results until each done pulse.
module tb_psa_seq_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] A, B;
  logic [15:0] Sum, Sum_w;
  logic [3:0]  Ovfl, Ovfl_w;
  logic        Error, Error_w;
  logic        busy, busy_w;
  logic        done, done_w;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum_s;
    logic [15:0] sum_w;
    logic [3:0]  ovfl;
    logic        err;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[10];

  psa_seq_unit #(.SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
    .Sum(Sum), .Ovfl(Ovfl), .Error(Error), .busy(busy), .done(done)
  );

  psa_seq_unit #(.SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
    .Sum(Sum_w), .Ovfl(Ovfl_w), .Error(Error_w), .busy(busy_w), .done(done_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference built from integer arithmetic on the signed lane values.
  function automatic vec_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    vec_t v;
    v.a = a; v.b = b; v.sub = s;
    v.sum_s = '0; v.sum_w = '0; v.ovfl = '0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] la, lb;
      int ia, ib, x;
      la = a[4*i +: 4];
      lb = b[4*i +: 4];
      ia = $signed(la);
      ib = $signed(lb);
      x = s ? ia - ib : ia + ib;
      v.ovfl[i] = (x > 7) || (x < -8);
      v.sum_w[4*i +: 4] = x[3:0];
      v.sum_s[4*i +: 4] = (x > 7) ? 4'h7 : (x < -8) ? 4'h8 : x[3:0];
    end
    v.err = |v.ovfl;
    return v;
  endfunction

  // Scoreboard: compare both instances against the oldest expected result on done.
  always @(negedge clk) begin
    if (rst_n && (done || done_w)) begin
      vec_t e;
      check("done_w_match", {15'd0, done_w}, {15'd0, done});
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_empty: got done with no pending op, expected none");
      end else begin
        e = sb.pop_front();
        check("sum_sat",  Sum,               e.sum_s);
        check("sum_wrap", Sum_w,             e.sum_w);
        check("ovfl_sat", {12'd0, Ovfl},     {12'd0, e.ovfl});
        check("ovfl_wrp", {12'd0, Ovfl_w},   {12'd0, e.ovfl});
        check("err_sat",  {15'd0, Error},    {15'd0, e.err});
        check("err_wrap", {15'd0, Error_w},  {15'd0, e.err});
      end
    end
  end

  // Issue one operation from IDLE and check handshake timing; entered at a negedge.
  task automatic run_op(input vec_t v);
    int lat;
    start = 1'b1; A = v.a; B = v.b; sub = v.sub;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0; A = ~v.a; B = ~v.b; sub = ~v.sub;
    check("busy_after_start", {15'd0, busy}, 16'd1);
    check("clear_sum",  Sum,  16'h0000);
    check("clear_ovfl", {12'd0, Ovfl}, 16'h0000);
    check("clear_err",  {15'd0, Error}, 16'h0000);
    lat = 0;
    while (lat < 9) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("done_latency", 16'(lat), 16'd4);
    @(negedge clk);
    check("done_pulse_end", {15'd0, done}, 16'd0);
    check("busy_end",       {15'd0, busy}, 16'd0);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h2345, 4'h0, 1'b0};
    tbl[1] = '{16'h7777, 16'h1111, 1'b0, 16'h7777, 16'h8888, 4'hF, 1'b1};
    tbl[2] = '{16'h8000, 16'h1000, 1'b1, 16'h8000, 16'h7000, 4'h8, 1'b1};
    tbl[3] = '{16'h5432, 16'h1111, 1'b1, 16'h4321, 16'h4321, 4'h0, 1'b0};
    tbl[4] = '{16'h8888, 16'h8888, 1'b0, 16'h8888, 16'h0000, 4'hF, 1'b1};
    tbl[5] = '{16'h7654, 16'h8888, 1'b1, 16'h7777, 16'hFEDC, 4'hF, 1'b1};
    tbl[6] = '{16'h7F18, 16'h1111, 1'b0, 16'h7029, 16'h8029, 4'h8, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 4'h0, 1'b0};
    tbl[8] = '{16'h0000, 16'h8888, 1'b1, 16'h7777, 16'h8888, 4'hF, 1'b1};
    tbl[9] = '{16'h3C5A, 16'h4C3B, 1'b0, 16'h7878, 16'h7885, 4'h3, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_sum",  Sum, 16'h0000);
    check("rst_ovfl", {12'd0, Ovfl}, 16'h0000);
    check("rst_err",  {15'd0, Error}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_done", {15'd0, done}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a run: partial result visible, then cleared asynchronously.
    start = 1'b1; A = 16'h1234; B = 16'h1111; sub = 1'b0;
    sb.push_back(tbl[0]);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_sum", Sum, 16'h0045);
    check("partial_busy", {15'd0, busy}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sum",  Sum, 16'h0000);
    check("midrst_ovfl", {12'd0, Ovfl}, 16'h0000);
    check("midrst_err",  {15'd0, Error}, 16'h0000);
    check("midrst_busy", {15'd0, busy}, 16'h0000);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", {15'd0, busy}, 16'h0000);

    // Table-driven operations.
    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Result hold after DONE with start low.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_sum",  Sum,   tbl[9].sum_s);
      check("hold_sumw", Sum_w, tbl[9].sum_w);
      check("hold_ovfl", {12'd0, Ovfl}, {12'd0, tbl[9].ovfl});
      check("hold_err",  {15'd0, Error}, {15'd0, tbl[9].err});
    end
    // Next start clears the held result at its sampling edge (checked inside run_op).
    run_op(ref_op(16'h1234, 16'h1111, 1'b0));

    // Start held high with operands changing every cycle: accepted only from IDLE.
    for (int k = 0; k < 18; k++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      start = 1'b1; A = ra; B = rb; sub = rs;
      if (k % 6 == 0) sb.push_back(ref_op(ra, rb, rs));
      @(negedge clk);
      check("hs_busy", {15'd0, busy}, {15'd0, ((k % 6) <= 4) ? 1'b1 : 1'b0});
      check("hs_done", {15'd0, done}, {15'd0, ((k % 6) == 4) ? 1'b1 : 1'b0});
    end
    start = 1'b0;

    // A few random single operations through the reference model.
    for (int k = 0; k < 6; k++)
      run_op(ref_op(16'($urandom), 16'($urandom), 1'($urandom)));

    repeat (3) @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
